// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader and the control decoder:
// MIPS opcodes, request-kind encodings and the loader FSM state type.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SUBI = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Request kinds; codes 12..15 are unassigned and treated as illegal.
  typedef enum logic [3:0] {
    KIND_R    = 4'd0,
    KIND_BEQ  = 4'd1,
    KIND_BNE  = 4'd2,
    KIND_LW   = 4'd3,
    KIND_SW   = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_SUBI = 4'd6,
    KIND_ORI  = 4'd7,
    KIND_XORI = 4'd8,
    KIND_ANDI = 4'd9,
    KIND_SLTI = 4'd10,
    KIND_J    = 4'd11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Opcode for the I-type kinds; other kinds return 0 and are handled by the caller.
  function automatic logic [5:0] kind_to_opcode(input logic [3:0] kind);
    logic [5:0] op;
    op = '0;
    case (kind)
      KIND_BEQ:  op = OP_BEQ;
      KIND_BNE:  op = OP_BNE;
      KIND_LW:   op = OP_LW;
      KIND_SW:   op = OP_SW;
      KIND_ADDI: op = OP_ADDI;
      KIND_SUBI: op = OP_SUBI;
      KIND_ORI:  op = OP_ORI;
      KIND_XORI: op = OP_XORI;
      KIND_ANDI: op = OP_ANDI;
      KIND_SLTI: op = OP_SLTI;
      default:   op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_instr_field_packer.sv
// Combinational packer: request kind plus operand fields -> 32-bit MIPS word.
// Fields are copied verbatim; no sign or zero extension happens here.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Select the instruction format from the kind and assemble the word.
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_R: o_word = {OP_R, i_rs, i_rt, i_rd, i_shamt, i_funct};
      KIND_J: o_word = {OP_J, i_target};
      KIND_BEQ, KIND_BNE, KIND_LW, KIND_SW, KIND_ADDI, KIND_SUBI,
      KIND_ORI, KIND_XORI, KIND_ANDI, KIND_SLTI:
        o_word = {kind_to_opcode(i_kind), i_rs, i_rt, i_imm};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts encode requests over valid/ready, packs
// each into a MIPS word and writes it to instruction memory at sequential
// addresses through a write/ack handshake. Stops at DEPTH words until cleared.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_ptr_eff;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_inc;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              r_we;
  logic              r_full;
  logic              r_err;
  logic              w_illegal;
  logic              w_ready;
  logic              w_accept;
  logic              w_clear_ok;

  instr_field_packer u_packer (
    .i_kind    (req_kind),
    .i_rs      (req_rs),
    .i_rt      (req_rt),
    .i_rd      (req_rd),
    .i_shamt   (req_shamt),
    .i_funct   (req_funct),
    .i_imm     (req_imm),
    .i_target  (req_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // clear is ignored while a write is in flight so that write always completes.
  assign w_clear_ok  = clear && (r_state != ST_WRITE);
  assign w_ready     = (r_state == ST_IDLE) && !r_full;
  assign w_accept    = req_valid && w_ready;
  assign w_count_inc = r_count + (ADDR_W + 1)'(1);
  // A clear coinciding with an accept restarts the program at address 0.
  assign w_ptr_eff   = w_clear_ok ? '0 : r_ptr;

  // Next-state logic for the IDLE/WRITE/FULL sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_illegal) w_next = ST_WRITE;
      ST_WRITE: if (imem_ack) w_next = (w_count_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
      ST_FULL:  if (clear) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Write strobe, address/data capture, pointer, count, full and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      case (r_state)
        ST_IDLE: begin
          if (w_clear_ok) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_addr  <= '0;
          end
          if (w_accept && !w_illegal) begin
            r_wdata <= w_word;
            r_addr  <= w_ptr_eff;
            r_we    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            r_we    <= 1'b0;
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_count <= w_count_inc;
            r_full  <= (w_count_inc == DEPTH_C);
          end
        end
        ST_FULL: begin
          if (w_clear_ok) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_addr  <= '0;
          end
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign count       = r_count;
  assign full        = r_full;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with DEPTH=4. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, clear, req_valid, req_ready, imem_we, imem_ack, full, err_illegal;
  logic [3:0]        req_kind;
  logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .count(count), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    clear = 0; req_valid = 0; imem_ack = 0; req_kind = 0; req_rs = 0; req_rt = 0;
    req_rd = 0; req_shamt = 0; req_funct = 0; req_imm = 0; req_target = 0;
  endtask

  task automatic present(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] tgt);
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_funct = fn; req_imm = imm; req_target = tgt; req_valid = 1;
  endtask

  task automatic pulse_clear();
    clear = 1; @(negedge clk); clear = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%h exp=0", imem_we); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    n_vec++; if (count !== 9'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got=%h exp=0", full); end
    n_vec++; if (err_illegal !== 1'b0) begin n_err++; $display("FAIL rst_err got=%h exp=0", err_illegal); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%h exp=1", req_ready); end
  endtask

  task automatic test_addi();
    present(4'd5, 5'd8, 5'd9, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready got=%h exp=1", req_ready); end
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL addi_we_pre got=%h exp=0", imem_we); end
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL addi_we got=%h exp=1", imem_we); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL addi_addr got=%h exp=00", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h21090005) begin n_err++; $display("FAIL addi_wdata got=%h exp=21090005", imem_wdata); end
    imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL addi_we_post got=%h exp=0", imem_we); end
    n_vec++; if (count !== 9'd1) begin n_err++; $display("FAIL addi_count got=%0d exp=1", count); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready_post got=%h exp=1", req_ready); end
  endtask

  task automatic test_r_delayed();
    pulse_clear();
    present(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
    @(negedge clk); req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL r_we[%0d] got=%h exp=1", i, imem_we); end
      n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL r_addr[%0d] got=%h exp=00", i, imem_addr); end
      n_vec++; if (imem_wdata !== 32'h01095020) begin n_err++; $display("FAIL r_wdata[%0d] got=%h exp=01095020", i, imem_wdata); end
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL r_ready[%0d] got=%h exp=0", i, req_ready); end
      if (i == 3) imem_ack = 1;
      req_valid = (i < 2); // requests offered during WRITE must not be taken
      @(negedge clk);
    end
    imem_ack = 0; req_valid = 0;
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL r_we_post got=%h exp=0", imem_we); end
    n_vec++; if (count !== 9'd1) begin n_err++; $display("FAIL r_count got=%0d exp=1", count); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    present(4'd3, 5'd29, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0);
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL b2b_lw_addr got=%h exp=00", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h8FA90004) begin n_err++; $display("FAIL b2b_lw_wdata got=%h exp=8fa90004", imem_wdata); end
    imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    present(4'd11, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%h exp=1", req_ready); end
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL b2b_j_we got=%h exp=1", imem_we); end
    n_vec++; if (imem_addr !== 8'h01) begin n_err++; $display("FAIL b2b_j_addr got=%h exp=01", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h08000010) begin n_err++; $display("FAIL b2b_j_wdata got=%h exp=08000010", imem_wdata); end
    imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    n_vec++; if (count !== 9'd2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", count); end
  endtask

  task automatic test_illegal();
    present(4'd13, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h1234, 26'h0);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got=%h exp=1", req_ready); end
    @(negedge clk); req_valid = 0;
    n_vec++; if (err_illegal !== 1'b1) begin n_err++; $display("FAIL ill_err got=%h exp=1", err_illegal); end
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL ill_we got=%h exp=0", imem_we); end
    n_vec++; if (count !== 9'd2) begin n_err++; $display("FAIL ill_count got=%0d exp=2", count); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready_post got=%h exp=1", req_ready); end
    @(negedge clk);
    n_vec++; if (err_illegal !== 1'b0) begin n_err++; $display("FAIL ill_err_end got=%h exp=0", err_illegal); end
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL ill_we_end got=%h exp=0", imem_we); end
  endtask

  task automatic test_fill();
    present(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hBEEF, 26'h0);
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_addr !== 8'h02) begin n_err++; $display("FAIL fill_ori_addr got=%h exp=02", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h3422BEEF) begin n_err++; $display("FAIL fill_ori_wdata got=%h exp=3422beef", imem_wdata); end
    imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    n_vec++; if (count !== 9'd3) begin n_err++; $display("FAIL fill_count3 got=%0d exp=3", count); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full3 got=%h exp=0", full); end
    present(4'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0);
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_addr !== 8'h03) begin n_err++; $display("FAIL fill_sw_addr got=%h exp=03", imem_addr); end
    n_vec++; if (imem_wdata !== 32'hAC64FFFC) begin n_err++; $display("FAIL fill_sw_wdata got=%h exp=ac64fffc", imem_wdata); end
    imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%h exp=1", full); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%h exp=0", req_ready); end
    n_vec++; if (count !== 9'd4) begin n_err++; $display("FAIL fill_count4 got=%0d exp=4", count); end
    present(4'd5, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0001, 26'h0);
    imem_ack = 1; // stray ack outside WRITE must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL full_we[%0d] got=%h exp=0", i, imem_we); end
      n_vec++; if (count !== 9'd4) begin n_err++; $display("FAIL full_count[%0d] got=%0d exp=4", i, count); end
    end
    req_valid = 0; imem_ack = 0;
    pulse_clear();
    n_vec++; if (count !== 9'd0) begin n_err++; $display("FAIL clr_count got=%0d exp=0", count); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL clr_full got=%h exp=0", full); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL clr_addr got=%h exp=00", imem_addr); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready got=%h exp=1", req_ready); end
  endtask

  task automatic test_reset_during_write();
    present(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0003, 26'h0);
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL rdw_we got=%h exp=1", imem_we); end
    n_vec++; if (imem_wdata !== 32'h10220003) begin n_err++; $display("FAIL rdw_wdata got=%h exp=10220003", imem_wdata); end
    reset = 1;
    @(negedge clk); reset = 0;
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL rdw_we_post got=%h exp=0", imem_we); end
    n_vec++; if (count !== 9'd0) begin n_err++; $display("FAIL rdw_count got=%0d exp=0", count); end
    n_vec++; if (imem_wdata !== 32'h0) begin n_err++; $display("FAIL rdw_wdata_post got=%h exp=0", imem_wdata); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rdw_ready got=%h exp=1", req_ready); end
  endtask

  task automatic test_clear_during_write();
    present(4'd10, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h8000, 26'h0);
    @(negedge clk); req_valid = 0;
    n_vec++; if (imem_wdata !== 32'h28A68000) begin n_err++; $display("FAIL cdw_wdata got=%h exp=28a68000", imem_wdata); end
    clear = 1;
    @(negedge clk);
    n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL cdw_we_held got=%h exp=1", imem_we); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL cdw_ready got=%h exp=0", req_ready); end
    clear = 0; imem_ack = 1;
    @(negedge clk); imem_ack = 0;
    n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL cdw_we_post got=%h exp=0", imem_we); end
    n_vec++; if (count !== 9'd1) begin n_err++; $display("FAIL cdw_count got=%0d exp=1", count); end
  endtask

  task automatic test_kinds();
    logic [3:0]  k   [5] = '{4'd2, 4'd6, 4'd8, 4'd9, 4'd11};
    logic [4:0]  rs  [5] = '{5'd31, 5'd2, 5'd4, 5'd6, 5'd31};
    logic [4:0]  rt  [5] = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd31};
    logic [15:0] imm [5] = '{16'hFFFF, 16'h0001, 16'h00FF, 16'h1234, 16'hFFFF};
    logic [25:0] tgt [5] = '{26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    logic [31:0] exp [5] = '{32'h17E0FFFF, 32'h24430001, 32'h388500FF, 32'h30C71234, 32'h0BFFFFFF};
    for (int i = 0; i < 5; i++) begin
      pulse_clear();
      present(k[i], rs[i], rt[i], 5'd31, 5'd31, 6'h3F, imm[i], tgt[i]);
      @(negedge clk); req_valid = 0;
      n_vec++; if (imem_wdata !== exp[i]) begin n_err++; $display("FAIL kind%0d_wdata got=%h exp=%h", k[i], imem_wdata, exp[i]); end
      n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL kind%0d_addr got=%h exp=00", k[i], imem_addr); end
      imem_ack = 1;
      @(negedge clk); imem_ack = 0;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_addi();
    test_r_delayed();
    test_back_to_back();
    test_illegal();
    test_fill();
    test_reset_during_write();
    test_clear_during_write();
    test_kinds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
